fan_ramp_controller: RTL

//  Parametrised N-level fan speed controller with soft-start/soft-stop duty ramping and glitch-free PWM.
//  Up/down speed pulses select a level. Each level maps to a target duty. Duty slews toward the target at a fixed rate.

---
 rtl/fan_ramp_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fan_ramp_controller.sv
// N-level fan speed controller: up/down level select, slewed duty ramp toward a
// per-level target, and a frame-latched PWM output that never glitches mid-frame.
module fan_ramp_controller #(
    parameter int SYS_FREQ_MHZ = 125,
    parameter int PWM_FREQ_HZ  = 200,
    parameter int DUTY_W       = 12,
    parameter int LEVELS       = 8,
    parameter int MIN_DUTY     = 1023,
    parameter int RAMP_STEP    = 16,
    parameter int RAMP_TICK_US = 1000,
    parameter int WRAP         = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      speed_up,
    input  logic                      speed_dn,
    input  logic                      fan_en,
    input  logic                      stop_req,
    output logic [$clog2(LEVELS)-1:0] level,
    output logic [LEVELS-1:0]         level_onehot,
    output logic [DUTY_W-1:0]         duty_cur,
    output logic                      ramping,
    output logic                      running,
    output logic                      pwm
);

    localparam int LW        = $clog2(LEVELS);
    localparam int DUTY_MAX  = (1 << DUTY_W) - 1;
    localparam int FRAME_CYC = (SYS_FREQ_MHZ * 1_000_000) / PWM_FREQ_HZ;
    localparam int PRE       = FRAME_CYC >> DUTY_W;
    localparam int PRE_W     = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int TICK_CYC  = RAMP_TICK_US * SYS_FREQ_MHZ;
    localparam int TICK_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [DUTY_W:0]   STEP_W1 = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [DUTY_W-1:0] STEP_N  = DUTY_W'(RAMP_STEP);

    if (PRE < 1) begin : g_pre_check
        $error("PWM prescaler is zero: frame too short for DUTY_W steps");
    end
    if (LEVELS < 3) begin : g_levels_check
        $error("LEVELS must be at least 3");
    end

    // Per-level target duties, flattened so the lookup is a plain mux on level.
    function automatic logic [LEVELS*DUTY_W-1:0] build_tgt();
        logic [LEVELS*DUTY_W-1:0] t;
        longint span;
        t    = '0;
        span = longint'(DUTY_MAX - MIN_DUTY);
        for (int k = 1; k < LEVELS; k++) begin
            t[k*DUTY_W +: DUTY_W] = DUTY_W'(longint'(MIN_DUTY) + (span * longint'(k - 1)) / longint'(LEVELS - 2));
        end
        return t;
    endfunction

    localparam logic [LEVELS*DUTY_W-1:0] TGT_TABLE = build_tgt();

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DN, HOLD} ramp_state_t;

    ramp_state_t       state, state_nxt;
    logic [LW-1:0]     level_nxt;
    logic [DUTY_W-1:0] tgt_cur, tgt_nxt, duty_ramp, duty_nxt;
    logic [DUTY_W:0]   up_sum, dn_lim;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick, forced;
    logic [PRE_W-1:0]  pre_cnt;
    logic              pre_adv;
    logic [DUTY_W-1:0] phase, duty_lat;

    assign forced  = !fan_en || stop_req;
    assign tgt_cur = TGT_TABLE[level*DUTY_W +: DUTY_W];
    assign tgt_nxt = TGT_TABLE[level_nxt*DUTY_W +: DUTY_W];
    assign tick    = (tick_cnt == TICK_W'(TICK_CYC - 1));
    assign pre_adv = (pre_cnt == PRE_W'(PRE - 1));
    assign up_sum  = {1'b0, duty_cur} + STEP_W1;
    assign dn_lim  = {1'b0, tgt_cur} + STEP_W1;

    always_comb begin
        level_nxt = level;
        if (forced) begin
            level_nxt = '0;
        end else if (speed_up && speed_dn) begin
            level_nxt = level;
        end else if (speed_up) begin
            if (level == LW'(LEVELS - 1)) level_nxt = (WRAP != 0) ? '0 : level;
            else                          level_nxt = level + LW'(1);
        end else if (speed_dn) begin
            if (level == '0) level_nxt = (WRAP != 0) ? LW'(LEVELS - 1) : level;
            else             level_nxt = level - LW'(1);
        end
    end

    // Steps are taken toward the target of the level currently held; a level
    // change lands this edge and is picked up as the new target on the next tick.
    always_comb begin
        duty_ramp = duty_cur;
        if (RAMP_STEP == 0) begin
            duty_ramp = tgt_cur;
        end else if (tick && state == RAMP_UP) begin
            duty_ramp = (up_sum > {1'b0, tgt_cur}) ? tgt_cur : up_sum[DUTY_W-1:0];
        end else if (tick && state == RAMP_DN) begin
            duty_ramp = ({1'b0, duty_cur} < dn_lim) ? tgt_cur : duty_cur - STEP_N;
        end
        duty_nxt = forced ? '0 : duty_ramp;
    end

    always_comb begin
        if (duty_nxt == tgt_nxt)     state_nxt = (tgt_nxt == '0) ? IDLE : HOLD;
        else if (duty_nxt < tgt_nxt) state_nxt = RAMP_UP;
        else                         state_nxt = RAMP_DN;
    end

    // NOTE: every register here uses <= so all state advances from the same
    // pre-edge snapshot; blocking assignments would leak new values across blocks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            level        <= '0;
            level_onehot <= LEVELS'(1);
            duty_cur     <= '0;
            ramping      <= 1'b0;
            running      <= 1'b0;
        end else begin
            state        <= state_nxt;
            level        <= level_nxt;
            level_onehot <= LEVELS'(1) << level_nxt;
            duty_cur     <= duty_nxt;
            ramping      <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DN);
            running      <= (duty_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) tick_cnt <= '0;
        else          tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
    end

    // duty_lat only reloads at the frame boundary, so each frame's high time is fixed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_cnt  <= '0;
            phase    <= '0;
            duty_lat <= '0;
            pwm      <= 1'b0;
        end else begin
            pre_cnt <= pre_adv ? '0 : pre_cnt + PRE_W'(1);
            if (pre_adv) begin
                phase <= phase + DUTY_W'(1);
                if (phase == '1) duty_lat <= duty_cur;
            end
            pwm <= (phase < duty_lat);
        end
    end

endmodule
